// File: rtl/heading_pid.sv
// heading_pid: two-stage PID heading controller producing saturated left/right motor speeds.
// Optional build macro PID_INT_DECIM_EN: the integrator accumulates only on every 4th accepted sample.
module heading_pid #(
    parameter logic signed [3:0] P_COEFF = 4'sd3,
    parameter logic signed [5:0] D_COEFF = 6'sd5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               moving,
    input  logic               err_vld,
    input  logic        [11:0] error,
    input  logic        [9:0]  frwrd,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd,
    output logic               spd_vld
);
    logic [9:0]  err_sat, prev_err;
    logic [10:0] diff;
    logic [7:0]  diff_sat;
    logic [13:0] p_next, d_next, p_reg, d_reg, pid;
    logic [15:0] integrator, int_sum;
    logic        int_ovf, acc, v1;
    logic [11:0] ival, lsum, rsum;
    logic [10:0] adj;

    // Stage-1 arithmetic: clamp error, P term, clamped derivative term, guarded integrator sum.
    always_comb begin
        err_sat  = (!error[11] && |error[10:9]) ? 10'h1FF :
                   (error[11] && !(&error[10:9])) ? 10'h200 : error[9:0];
        diff     = {err_sat[9], err_sat} - {prev_err[9], prev_err};
        diff_sat = (diff[10:7] == 4'h0 || diff[10:7] == 4'hF) ? diff[7:0] :
                   (diff[10] ? 8'h80 : 8'h7F);
        p_next   = {{4{err_sat[9]}}, err_sat} * {{10{P_COEFF[3]}}, P_COEFF};
        d_next   = {{6{diff_sat[7]}}, diff_sat} * {{8{D_COEFF[5]}}, D_COEFF};
        int_sum  = integrator + {{6{err_sat[9]}}, err_sat};
        int_ovf  = (integrator[15] == err_sat[9]) && (int_sum[15] != integrator[15]);
    end

    // Stage-2 arithmetic: combine terms, floor-divide by 8 and saturate both wheel speeds.
    always_comb begin
        ival = integrator[15:4];
        pid  = p_reg + {{2{ival[11]}}, ival} + d_reg;
        adj  = pid[13:3];
        lsum = {2'b00, frwrd} + {adj[10], adj};
        rsum = {2'b00, frwrd} - {adj[10], adj};
    end

`ifdef PID_INT_DECIM_EN
    logic [1:0] cnt;
    assign acc = (cnt == 2'd3);
    // Sample counter that gates integration to every 4th accepted error.
    always_ff @(posedge clk) begin
        if (rst || !moving)
            cnt <= 2'd0;
        else if (err_vld)
            cnt <= cnt + 2'd1;
    end
`else
    assign acc = 1'b1;
`endif

    // Pipeline registers; reset or a stopped robot clears everything including in-flight samples.
    always_ff @(posedge clk) begin
        if (rst || !moving) begin
            prev_err   <= '0;
            p_reg      <= '0;
            d_reg      <= '0;
            integrator <= '0;
            v1         <= 1'b0;
            lft_spd    <= '0;
            rght_spd   <= '0;
            spd_vld    <= 1'b0;
        end else begin
            v1      <= err_vld;
            spd_vld <= v1;
            if (err_vld) begin
                p_reg    <= p_next;
                d_reg    <= d_next;
                prev_err <= err_sat;
                if (acc && !int_ovf)
                    integrator <= int_sum;
            end
            if (v1) begin
                lft_spd  <= (lsum[11] != lsum[10]) ? (lsum[11] ? 11'h400 : 11'h3FF) : lsum[10:0];
                rght_spd <= (rsum[11] != rsum[10]) ? (rsum[11] ? 11'h400 : 11'h3FF) : rsum[10:0];
            end
        end
    end
endmodule
